// File: rtl/a1csa_pkg.sv
// Shared definitions for the segmented approximate carry-select adder controller.
package a1csa_pkg;

  // Controller states: accept operands, speculate, correct, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPEC = 2'd1,
    FIX  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Number of adder segments for a given operand and segment width.
  function automatic int nseg(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/a1csa_vlat_ctrl_if.sv
// Operand/result handshake bundle between producer, controller and consumer.
interface a1csa_vlat_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             corr_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             err;
  logic [CNTW-1:0]  err_cnt;

  // Producer/consumer side.
  modport master (
    output in_valid, a, b, cin, corr_en, out_ready,
    input  in_ready, out_valid, sum, cout, err, err_cnt
  );

  // Controller side.
  modport slave (
    input  in_valid, a, b, cin, corr_en, out_ready,
    output in_ready, out_valid, sum, cout, err, err_cnt
  );
endinterface

// File: rtl/a1csa_seg_add.sv
// One SEG-bit ripple slice of the carry-select adder.
module a1csa_seg_add #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);
  assign {co, s} = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
endmodule

// File: rtl/a1csa_vlat_ctrl.sv
// Variable-latency controller: speculative segmented add, misprediction
// detection and an optional one-cycle exact recompute.
module a1csa_vlat_ctrl
  import a1csa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int CNTW  = 16
) (
  input logic               clk,
  input logic               rst_n,
  a1csa_vlat_ctrl_if.slave  bus
);
  localparam int NSEG = nseg(WIDTH, SEG);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             cin_reg, corr_reg, cout_reg, err_reg;
  logic [CNTW-1:0]  err_cnt_reg;

  logic             load_in, load_out, err_set, mispredict, top_co;
  logic [WIDTH-1:0] seg_sum;
  logic [NSEG-1:0]  miss;

  // Per segment: speculated carry = generate of the segment below (carry-in 0),
  // true carry = segment-level lookahead chain. In FIX the slices ripple their
  // own carry-outs, which yields the exact sum through the same adders.
  for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
    logic [SEG-1:0] x, y;
    logic           spec_ci, true_ci, ci_sel, co;
    assign x = a_reg[gi*SEG +: SEG];
    assign y = b_reg[gi*SEG +: SEG];
    if (gi == 0) begin : g_first
      assign spec_ci = cin_reg;
      assign true_ci = cin_reg;
      assign ci_sel  = cin_reg;
    end else begin : g_rest
      assign spec_ci = ({1'b0, g_seg[gi-1].x} + {1'b0, g_seg[gi-1].y}) > {1'b0, {SEG{1'b1}}};
      assign true_ci = spec_ci | ((&(g_seg[gi-1].x ^ g_seg[gi-1].y)) & g_seg[gi-1].true_ci);
      assign ci_sel  = (state_reg == FIX) ? g_seg[gi-1].co : spec_ci;
    end
    assign miss[gi] = spec_ci ^ true_ci;
    a1csa_seg_add #(.SEG(SEG)) u_slice (
      .x  (x),
      .y  (y),
      .ci (ci_sel),
      .s  (seg_sum[gi*SEG +: SEG]),
      .co (co)
    );
  end

  assign top_co     = g_seg[NSEG-1].co;
  assign mispredict = |miss;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and datapath load strobes.
  always_comb begin
    state_next = state_reg;
    load_in    = 1'b0;
    load_out   = 1'b0;
    err_set    = 1'b0;
    case (state_reg)
      IDLE: if (bus.in_valid) begin
        load_in    = 1'b1;
        state_next = SPEC;
      end
      SPEC: if (mispredict && corr_reg) begin
        state_next = FIX;
      end else begin
        load_out   = 1'b1;
        err_set    = mispredict;
        state_next = OUT;
      end
      FIX: begin
        load_out   = 1'b1;
        err_set    = 1'b1;
        state_next = OUT;
      end
      OUT: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, result registers and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      cin_reg     <= 1'b0;
      corr_reg    <= 1'b0;
      sum_reg     <= '0;
      cout_reg    <= 1'b0;
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      if (load_in) begin
        a_reg    <= bus.a;
        b_reg    <= bus.b;
        cin_reg  <= bus.cin;
        corr_reg <= bus.corr_en;
      end
      if (load_out) begin
        sum_reg  <= seg_sum;
        cout_reg <= top_co;
        err_reg  <= err_set;
        if (err_set && (err_cnt_reg != {CNTW{1'b1}}))
          err_cnt_reg <= err_cnt_reg + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == OUT);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.err       = err_reg;
  assign bus.err_cnt   = err_cnt_reg;
endmodule

// File: tb/tb_a1csa_vlat_ctrl.sv
// Scoreboard bench for a1csa_vlat_ctrl: directed cases, random operands, a
// reset-during-FIX case and error-counter saturation on a narrow-counter copy.
module tb_a1csa_vlat_ctrl;
  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        err;
    int          lat;
    logic [15:0] cnt;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  a1csa_vlat_ctrl_if #(.WIDTH(16), .CNTW(16)) bus ();
  a1csa_vlat_ctrl_if #(.WIDTH(16), .CNTW(2))  sbus ();

  a1csa_vlat_ctrl #(.WIDTH(16), .SEG(4), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  a1csa_vlat_ctrl #(.WIDTH(16), .SEG(4), .CNTW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sbus)
  );

  exp_t        exp_q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  logic [15:0] model_cnt = '0;
  bit          hold_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s bound expired", name);
  endtask

  // Reference: speculative carries are the no-carry-in generate of the segment
  // below; true carries come from the full low-order sum.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic corr);
    exp_t r;
    int unsigned ua, ub, uc, exact, spec_sum, spec_cout, xa, xb, ci_spec, ci_true, lowmask, t;
    bit miss;
    ua = a; ub = b; uc = cin;
    exact = ua + ub + uc;
    spec_sum = 0; spec_cout = 0; miss = 0;
    for (int i = 0; i < 4; i++) begin
      xa = (ua >> (4*i)) & 15;
      xb = (ub >> (4*i)) & 15;
      if (i == 0) begin
        ci_spec = uc;
        ci_true = uc;
      end else begin
        ci_spec = (((ua >> (4*(i-1))) & 15) + ((ub >> (4*(i-1))) & 15)) >> 4;
        lowmask = (32'd1 << (4*i)) - 1;
        ci_true = ((ua & lowmask) + (ub & lowmask) + uc) >> (4*i);
      end
      if (ci_spec != ci_true) miss = 1'b1;
      t = xa + xb + ci_spec;
      spec_sum = spec_sum | ((t & 15) << (4*i));
      spec_cout = t >> 4;
    end
    if (miss && corr) begin
      r.sum = 16'(exact); r.cout = exact[16]; r.err = 1'b1; r.lat = 3;
    end else begin
      r.sum = 16'(spec_sum); r.cout = spec_cout[0]; r.err = miss; r.lat = 2;
    end
    r.cnt = '0;
    r.acc = 0;
    return r;
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic corr);
    int   n;
    exp_t e;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.corr_en = corr; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      timeout("accept_wait");
      bus.in_valid = 1'b0;
      return;
    end
    e = model(a, b, cin, corr);
    if (e.err && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    e.cnt = model_cnt;
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || bus.out_valid) timeout("drain_wait");
  endtask

  task automatic sat_op(input logic corr, input logic [1:0] want);
    int n;
    @(negedge clk);
    sbus.a = 16'h00FF; sbus.b = 16'h0001; sbus.cin = 1'b0; sbus.corr_en = corr; sbus.in_valid = 1'b1;
    n = 0;
    while (!sbus.in_ready && n < 20) begin @(negedge clk); n++; end
    if (!sbus.in_ready) begin timeout("sat_accept"); sbus.in_valid = 1'b0; return; end
    @(negedge clk);
    sbus.in_valid = 1'b0;
    n = 0;
    while (!sbus.out_valid && n < 10) begin @(negedge clk); n++; end
    if (!sbus.out_valid) begin timeout("sat_out"); return; end
    check("sat_err", sbus.err, 1);
    check("sat_err_cnt", sbus.err_cnt, want);
    $display("sat op corr=%0d err_cnt=%0d", corr, sbus.err_cnt);
  endtask

  // Consumer: random back-pressure, or held off while hold_ready is set.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on the first cycle of each result and checks
  // that held results stay stable while in_ready stays low.
  initial begin
    bit          active;
    exp_t        e;
    logic [15:0] hs;
    logic        hc, he;
    active = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
      end else if (bus.out_valid) begin
        check("in_ready_in_out", bus.in_ready, 0);
        if (!active) begin
          active = 1'b1;
          if (exp_q.size() == 0) begin
            timeout("unexpected_output");
          end else begin
            e = exp_q.pop_front();
            check("sum", bus.sum, e.sum);
            check("cout", bus.cout, e.cout);
            check("err", bus.err, e.err);
            check("err_cnt", bus.err_cnt, e.cnt);
            check("latency", cyc - e.acc + 1, e.lat);
            $display("txn sum=%h cout=%0d err=%0d err_cnt=%0d lat=%0d",
                     bus.sum, bus.cout, bus.err, bus.err_cnt, cyc - e.acc + 1);
          end
          hs = bus.sum; hc = bus.cout; he = bus.err;
        end else begin
          check("hold_sum", bus.sum, hs);
          check("hold_cout", bus.cout, hc);
          check("hold_err", bus.err, he);
        end
        if (bus.out_ready) active = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] ra, rb;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.corr_en = 1'b0;
    sbus.in_valid = 1'b0; sbus.a = '0; sbus.b = '0; sbus.cin = 1'b0; sbus.corr_en = 1'b0;
    sbus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_err", bus.err, 0);
    check("rst_err_cnt", bus.err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(16'h0001, 16'h0002, 1'b0, 1'b1);
    issue(16'h000F, 16'h0001, 1'b0, 1'b1);
    issue(16'h00FF, 16'h0001, 1'b0, 1'b1);
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_drain();

    // Result held under back-pressure.
    hold_ready = 1'b1;
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    if (!bus.out_valid) timeout("hold_out_wait");
    repeat (5) @(negedge clk);
    hold_ready = 1'b0;
    wait_drain();

    // Random operands, biased towards long carry chains.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = 16'(~ra + 16'($urandom_range(0, 3)));
        1:       rb = 16'($urandom_range(0, 15));
        default: rb = 16'($urandom);
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_drain();

    // Reset while in FIX discards the operation and clears the counter.
    issue(16'h00FF, 16'h0001, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    model_cnt = '0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_err_cnt", bus.err_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(16'h00FF, 16'h0001, 1'b0, 1'b1);
    wait_drain();

    // Saturation on the 2-bit counter copy.
    sat_op(1'b1, 2'd1);
    sat_op(1'b0, 2'd2);
    sat_op(1'b1, 2'd3);
    sat_op(1'b0, 2'd3);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
